// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared definitions for the round-robin arbiter: default
//                sizes, the controller state encoding and a helper that turns
//                an encoded index into a one-hot vector.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int c_n_def    = 8;   // default number of requesters
    localparam int c_idxw_def = 3;   // default index width, clog2(c_n_def)
    localparam int c_max_n    = 16;  // largest supported requester count
    localparam int c_max_idxw = 4;   // index width for c_max_n

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Returns a c_max_n-wide one-hot vector; callers size-cast to their N.
    function automatic logic [c_max_n-1:0] onehot(input logic [c_max_idxw-1:0] idx);
        logic [c_max_n-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotating priority encoder. Rotates the request
//                vector so that position ptr becomes bit 0, finds the lowest
//                set bit, then adds ptr back to recover the real index.
//                An optional mask removes one requester from consideration.
//  Ports       : req      - request vector
//                ptr      - highest-priority index
//                mask_idx - index to exclude when mask_en is set
//                mask_en  - enable the exclusion
//                win_idx  - winning index (valid only when any=1)
//                any      - at least one unmasked request is present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N    = 8,
    parameter int IDXW = 3
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    input  logic [IDXW-1:0] mask_idx,
    input  logic            mask_en,
    output logic [IDXW-1:0] win_idx,
    output logic            any
);

    logic [N-1:0]    w_req_m;
    logic [N-1:0]    w_rot;
    logic [IDXW-1:0] w_off;

    always_comb begin
        w_req_m = req;
        if (mask_en) begin
            w_req_m[mask_idx] = 1'b0;
        end

        // N is a power of two, so IDXW-bit addition wraps modulo N.
        w_rot = '0;
        for (int i = 0; i < N; i++) begin
            w_rot[i] = w_req_m[ptr + IDXW'(i)];
        end

        // Scan downwards so the lowest set bit is the last one written.
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDXW'(i);
            end
        end
    end

    assign win_idx = ptr + w_off;
    assign any     = |w_req_m;

endmodule : rr_pick
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter for N requesters. A grant is held until
//                its owner drops req; on release the priority pointer moves
//                one past the owner and the next winner is granted with no
//                idle gap. All outputs are registered.
//  Ports       : clk         - system clock, rising edge
//                rst         - synchronous reset, active high
//                req         - request vector
//                grant       - one-hot grant, zero when idle
//                grant_idx   - encoded owner index, holds when idle
//                grant_valid - high while a grant is active
//                timeout     - one-cycle pulse on a forced revoke
//  Options     : ARB_TIMEOUT_EN - when defined, a grant held for MAX_HOLD
//                cycles is revoked if another requester is waiting.
//                Otherwise timeout is tied low and grants never expire.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N        = c_n_def,
    parameter int IDXW     = c_idxw_def,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_valid,
    output logic            timeout
);

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            valid_q, valid_d;
    logic [IDXW-1:0] ptr_q, ptr_d;

    logic [IDXW-1:0] w_next_ptr;
    logic [IDXW-1:0] w_pick_ptr;
    logic [IDXW-1:0] w_win_idx;
    logic            w_any;
    logic            w_busy;
    logic            w_release;
    logic            w_revoke;
    logic            w_load;

    assign w_busy     = (state_q == BUSY);
    assign w_next_ptr = idx_q + IDXW'(1);
    assign w_release  = w_busy && !req[idx_q];

`ifdef ARB_TIMEOUT_EN
    localparam int c_holdw = $clog2(MAX_HOLD + 1);

    logic [c_holdw-1:0] hold_q, hold_d;
    logic               timeout_q, timeout_d;
    logic               w_hold_max;

    assign w_hold_max = (hold_q == c_holdw'(MAX_HOLD - 1));
    // Only revoke when someone else is waiting; the owner is masked below.
    assign w_revoke   = w_busy && req[idx_q] && w_hold_max && w_any;
`else
    assign w_revoke   = 1'b0;
`endif

    // Pointer used for this cycle's pick: one past the owner when the grant
    // is being handed on, otherwise the stored pointer. Kept outside the
    // next-state block so the pick never depends on its own result.
    assign w_pick_ptr = (w_release || (w_busy && req[idx_q])) ? w_next_ptr : ptr_q;

    // While BUSY the owner is always excluded: on release its bit is already
    // zero, and on a revoke it must not win again.
    rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req      (req),
        .ptr      (w_pick_ptr),
        .mask_idx (idx_q),
        .mask_en  (w_busy),
        .win_idx  (w_win_idx),
        .any      (w_any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        w_load  = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_any) begin
                    w_load  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (w_release || w_revoke) begin
                    ptr_d = w_next_ptr;
                    if (w_any) begin
                        w_load = 1'b1;
                    end else begin
                        grant_d = '0;
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (w_load) begin
            grant_d = N'(onehot(c_max_idxw'(w_win_idx)));
            idx_d   = w_win_idx;
            valid_d = 1'b1;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_comb begin
        timeout_d = w_revoke;
        hold_d    = hold_q;
        if (w_load) begin
            hold_d = '0;
        end else if (w_busy && !w_hold_max) begin
            hold_d = hold_q + c_holdw'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;

endmodule : rr_arbiter
`default_nettype wire

// File: tb/tb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter
//  Description : Directed self-checking bench for rr_arbiter (N=8). Inputs
//                change one time unit after the rising edge; outputs are
//                checked at the same point, after the edge has settled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int n_vec  = 0;
    int n_fail = 0;

    rr_arbiter #(
        .N        (8),
        .IDXW     (3),
        .MAX_HOLD (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [7:0] eg, input logic [2:0] ei,
                             input logic ev);
        chk({tag, ".grant"}, 32'(grant), 32'(eg));
        chk({tag, ".idx"},   32'(grant_idx), 32'(ei));
        chk({tag, ".valid"}, 32'(grant_valid), 32'(ev));
    endtask

    initial begin
        rst = 1'b1;
        req = 8'hFF;

        // Reset with every request asserted
        tick();
        tick();
        chk_grant("reset", 8'h00, 3'd0, 1'b0);
        chk("reset.timeout", 32'(timeout), 32'd0);

        // First arbitration after reset: pointer 0 wins
        rst = 1'b0;
        tick();
        chk_grant("post_reset", 8'h01, 3'd0, 1'b1);

        // Drop everything -> idle, index holds; pointer now 1
        req = 8'h00;
        tick();
        chk_grant("idle_after_release", 8'h00, 3'd0, 1'b0);

        // Single requester 5 held for five cycles
        req = 8'h20;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_grant($sformatf("single_hold%0d", k), 8'h20, 3'd5, 1'b1);
        end
        req = 8'h00;
        tick();
        chk_grant("single_drop", 8'h00, 3'd5, 1'b0);

        // Rotation from a clean pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'hFF;
        tick();
        chk_grant("rot0", 8'h01, 3'd0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            // the previous owner (k-1) drops for one cycle
            req = 8'hFF & ~(8'h01 << ((k - 1) % 8));
            tick();
            chk_grant($sformatf("rot%0d", k), 8'h01 << (k % 8), 3'(k % 8), 1'b1);
        end
        chk("rot.timeout", 32'(timeout), 32'd0);

        // Release all (owner 0 -> pointer 1); then serve 2 to move pointer to 3
        req = 8'h00;
        tick();
        req = 8'h04;
        tick();
        chk_grant("fair_setup", 8'h04, 3'd2, 1'b1);
        req = 8'h00;
        tick();
        chk_grant("fair_idle", 8'h00, 3'd2, 1'b0);

        // Fairness: 2 and 6 pending with pointer 3 -> 6 first
        req = 8'h44;
        tick();
        chk_grant("fair_first", 8'h40, 3'd6, 1'b1);
        req = 8'h04;
        tick();
        chk_grant("fair_second", 8'h04, 3'd2, 1'b1);
        req = 8'h44;
        tick();
        chk_grant("fair_no_preempt", 8'h04, 3'd2, 1'b1);
        req = 8'h40;
        tick();
        chk_grant("fair_back_to_6", 8'h40, 3'd6, 1'b1);

        // Mid-grant reset: owner 6 releases (pointer 7), then 4 is granted
        req = 8'h00;
        tick();
        req = 8'h10;
        tick();
        chk_grant("midrst_pre", 8'h10, 3'd4, 1'b1);
        rst = 1'b1;
        req = 8'h90;
        tick();
        chk_grant("midrst", 8'h00, 3'd0, 1'b0);
        rst = 1'b0;
        tick();
        // pointer back at 0 -> index 4 beats 7
        chk_grant("midrst_next", 8'h10, 3'd4, 1'b1);

`ifdef ARB_TIMEOUT_EN
        // Forced rotation: 1 holds, 3 waits
        rst = 1'b1;
        req = 8'h00;
        tick();
        rst = 1'b0;
        req = 8'h0A;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("to_hold%0d.grant", k), 32'(grant), 32'h02);
            chk($sformatf("to_hold%0d.timeout", k), 32'(timeout), 32'd0);
        end
        tick();
        chk_grant("to_revoke", 8'h08, 3'd3, 1'b1);
        chk("to_revoke.timeout", 32'(timeout), 32'd1);
        tick();
        chk("to_after.grant", 32'(grant), 32'h08);
        chk("to_after.timeout", 32'(timeout), 32'd0);

        // Lone owner is never revoked
        rst = 1'b1;
        req = 8'h00;
        tick();
        rst = 1'b0;
        req = 8'h02;
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk($sformatf("to_lone%0d.grant", k), 32'(grant), 32'h02);
            chk($sformatf("to_lone%0d.timeout", k), 32'(timeout), 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_rr_arbiter
`default_nettype wire
